keypad_scan_ctrl: RTL

//  Sequences the 4x4 matrix keypad: drives the column strobes and samples the rows.

---
 rtl/keypad_pkg.sv | 39 +++
 rtl/keypad_event_fifo.sv | 62 ++++++
 rtl/keypad_scan_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and the key-code map for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {COL0, COL1, COL2, COL3} scan_state_t;

  localparam key_code_t KEY_STAR = 4'hE;
  localparam key_code_t KEY_HASH = 4'hF;

  // Column 3 is the letter column, so A..D follow the row index directly.
  function automatic key_code_t key_code(input logic [1:0] col_idx, input logic [1:0] row_idx);
    key_code_t code;
    code = '0;
    case (col_idx)
      2'd0: case (row_idx)
        2'd0: code = 4'h1;
        2'd1: code = 4'h4;
        2'd2: code = 4'h7;
        default: code = KEY_STAR;
      endcase
      2'd1: case (row_idx)
        2'd0: code = 4'h2;
        2'd1: code = 4'h5;
        2'd2: code = 4'h8;
        default: code = 4'h0;
      endcase
      2'd2: case (row_idx)
        2'd0: code = 4'h3;
        2'd1: code = 4'h6;
        2'd2: code = 4'h9;
        default: code = KEY_HASH;
      endcase
      default: code = 4'hA + {2'b00, row_idx};
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Key-event FIFO with first-word fall-through head and a sticky overflow flag.
module keypad_event_fifo
  import keypad_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  key_code_t push_data,
  input  logic      pop,
  input  logic      ovf_clr,
  output key_code_t rd_data,
  output logic      empty,
  output logic      full,
  output logic      overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic        do_push, do_pop, drop;
  key_code_t   mem_q [FIFO_DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees the slot the same cycle, so a push into a full FIFO with a pop is not a drop.
  always_comb begin
    do_pop     = pop && !empty;
    do_push    = push && (!full || do_pop);
    drop       = push && full && !do_pop;
    wr_ptr_d   = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d   = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    overflow_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

  assign rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign overflow = overflow_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column strobing, pass-level debounce, decode and event queue.
// Optional auto-repeat of a held key is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int REPEAT_DELAY   = 40,
  parameter int REPEAT_RATE    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  input  logic       rd_en,
  output logic [3:0] rd_data,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic       key_down
);

  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STAB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_TGT = STAB_W'(DEBOUNCE_SCANS);

  // An out-of-range configuration shows up as g_bad_params in the elaborated hierarchy.
  if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || FIFO_DEPTH < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
  end

  scan_state_t       state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [15:0]       raw_q, raw_d, raw_prev_q, raw_prev_d, deb_q, deb_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic              pass_end, deb_changed, new_single, push;
  key_code_t         push_code;

  assign col = 4'b0001 << state_q;

  // The whole matrix is judged once per pass, when column 3 has just been sampled.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q + DIV_W'(1);
    raw_d      = raw_q;
    raw_prev_d = raw_prev_q;
    stab_cnt_d = stab_cnt_q;
    deb_d      = deb_q;
    pass_end   = 1'b0;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      raw_d[{state_q, 2'b00} +: 4] = ~row;
      case (state_q)
        COL0:    state_d = COL1;
        COL1:    state_d = COL2;
        COL2:    state_d = COL3;
        default: state_d = COL0;
      endcase
      if (state_q == COL3) begin
        pass_end   = 1'b1;
        raw_prev_d = raw_d;
        if (raw_d == raw_prev_q)
          stab_cnt_d = (stab_cnt_q == STAB_TGT) ? stab_cnt_q : stab_cnt_q + STAB_W'(1);
        else
          stab_cnt_d = STAB_W'(1);
        if (stab_cnt_d == STAB_TGT) deb_d = raw_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= COL0;
      div_cnt_q  <= '0;
      raw_q      <= '0;
      raw_prev_q <= '0;
      stab_cnt_q <= '0;
      deb_q      <= '0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      raw_q      <= raw_d;
      raw_prev_q <= raw_prev_d;
      stab_cnt_q <= stab_cnt_d;
      deb_q      <= deb_d;
    end
  end

  always_comb begin
    deb_changed = (deb_d != deb_q);
    new_single  = ($countones(deb_d) == 1);
    push_code   = '0;
    for (int i = 0; i < 16; i++)
      if (deb_d[i]) push_code = key_code(2'(i / 4), 2'(i % 4));
  end

  assign key_down = ($countones(deb_q) == 1);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_next;
  logic             rep_phase_q, rep_phase_d, rep_fire;

  // rep_phase separates the long initial delay from the shorter steady repeat interval.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    rep_fire    = 1'b0;
    rep_next    = rep_cnt_q + REP_W'(1);
    if (pass_end) begin
      if (deb_changed) begin
        rep_cnt_d   = '0;
        rep_phase_d = 1'b0;
      end else if (new_single) begin
        if (rep_next == (rep_phase_q ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY))) begin
          rep_fire    = 1'b1;
          rep_cnt_d   = '0;
          rep_phase_d = 1'b1;
        end else begin
          rep_cnt_d = rep_next;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
    end
  end

  assign push = (pass_end && deb_changed && new_single) || rep_fire;
`else
  assign push = pass_end && deb_changed && new_single;
`endif

  keypad_event_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_code),
    .pop      (rd_en),
    .ovf_clr  (ovf_clr),
    .rd_data  (rd_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .overflow (overflow)
  );

endmodule
